// File: rtl/dft_addsub_sched.sv
// Round-robin scheduler sharing one DFT adder-subtractor among N_REQ requesters.
// Optional macro DFT_ADDSUB_SCHED_LOCK_EN adds req_lock so a granted requester keeps priority for bursts.
module dft_addsub_sched #(
  parameter int DATA_W     = 32,
  parameter int N_REQ      = 4,
  parameter int ADDSUB_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_addsub,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
`ifdef DFT_ADDSUB_SCHED_LOCK_EN
  input  logic [N_REQ-1:0]        req_lock,
`endif
  output logic                    as_addsub,
  output logic [DATA_W-1:0]       as_data_a,
  output logic [DATA_W-1:0]       as_data_b,
  input  logic [DATA_W-1:0]       as_result,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              gnt_any;
  logic [PTR_W-1:0]  gnt_id;
  logic              lock_g;

  logic              as_addsub_q, as_addsub_d;
  logic [DATA_W-1:0] as_data_a_q, as_data_a_d;
  logic [DATA_W-1:0] as_data_b_q, as_data_b_d;

  // Stage 0 is the issue stage, alongside the as_* registers; the last stage aligns with as_result.
  logic [ADDSUB_LAT:0]            tag_vld_q, tag_vld_d;
  logic [ADDSUB_LAT:0][PTR_W-1:0] tag_id_q, tag_id_d;

  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_any && req_valid[idx[PTR_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = idx[PTR_W-1:0];
      end
    end
  end

`ifdef DFT_ADDSUB_SCHED_LOCK_EN
  assign lock_g = req_lock[gnt_id];
`else
  assign lock_g = 1'b0;
`endif

  assign req_ready = (gnt_any && !rst) ? (N_REQ'(1) << gnt_id) : '0;

  always_comb begin
    ptr_d       = ptr_q;
    as_addsub_d = as_addsub_q;
    as_data_a_d = as_data_a_q;
    as_data_b_d = as_data_b_q;
    if (gnt_any) begin
      if (lock_g)
        ptr_d = gnt_id;
      else if (gnt_id == PTR_W'(N_REQ - 1))
        ptr_d = '0;
      else
        ptr_d = gnt_id + PTR_W'(1);
      as_addsub_d = req_addsub[gnt_id];
      as_data_a_d = req_a[int'(gnt_id)*DATA_W +: DATA_W];
      as_data_b_d = req_b[int'(gnt_id)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = gnt_any;
    tag_id_d[0]  = gnt_id;
    for (int k = 1; k <= ADDSUB_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      as_addsub_q <= 1'b0;
      as_data_a_q <= '0;
      as_data_b_q <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      as_addsub_q <= as_addsub_d;
      as_data_a_q <= as_data_a_d;
      as_data_b_q <= as_data_b_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
    end
  end

  assign as_addsub = as_addsub_q;
  assign as_data_a = as_data_a_q;
  assign as_data_b = as_data_b_q;
  assign rsp_valid = tag_vld_q[ADDSUB_LAT] ? (N_REQ'(1) << tag_id_q[ADDSUB_LAT]) : '0;
  assign rsp_data  = as_result;

endmodule
